dac_sine_sequencer: RTL and testbench

- Sequences full-wave sine generation for a single DAC channel from a quarter-wave magnitude LUT.
- Paces samples at a programmable period and walks the LUT address up and down across four quadrants.
- Applies the quadrant sign around mid-scale and issues one SPI write per sample, using a strobe/end-of-write handshake with the existing SPI writer.
- Sits between the quarter-wave ROM and the SPI write FSM.

---
 rtl/dac_sine_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_dac_sine_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sine_sequencer.sv
// dac_sine_sequencer
// Builds a full-wave sine for one DAC channel from a quarter-wave magnitude
// ROM. A programmable pace counter issues sample ticks. Each tick fetches one
// LUT point, applies the quadrant sign around mid-scale, and hands the word to
// the SPI writer through a strobe / end-of-write handshake. The LUT address
// walks up in quadrants 0 and 2 and down in quadrants 1 and 3.
module dac_sine_sequencer #(
    parameter int N_PTS  = 20,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int DIV_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  period_i,
    output logic [ADDR_W-1:0] lut_addr_o,
    input  logic [DATA_W-2:0] lut_data_i,
    output logic [DATA_W-1:0] dac_data_o,
    output logic              strw_o,
    input  logic              eow_i,
    output logic [1:0]        quad_o,
    output logic              busy_o,
    output logic              cycle_o,
    output logic              ovr_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FETCH = 3'd2,
        S_LOAD  = 3'd3,
        S_STRB  = 3'd4,
        S_BUSY  = 3'd5,
        S_ADV   = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PTS - 1);
    localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [1:0]        QUAD_ZERO = 2'd0;
    localparam logic [1:0]        QUAD_ONE  = 2'd1;
    localparam logic [1:0]        QUAD_LAST = 2'd3;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [DIV_W-1:0]   cnt_r;
    logic [DIV_W-1:0]   reload_s;
    logic               tick_s;

    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  addr_nxt_s;
    logic [1:0]         quad_r;
    logic [1:0]         quad_nxt_s;
    logic [DATA_W-1:0]  dac_r;
    logic [DATA_W-1:0]  dac_nxt_s;
    logic [DATA_W-1:0]  lut_ext_s;
    logic               strw_r;
    logic               strw_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               cycle_r;
    logic               cycle_nxt_s;
    logic               ovr_r;
    logic               ovr_nxt_s;

    // Zero-extend the unsigned LUT magnitude to the DAC word width.
    assign lut_ext_s = {1'b0, lut_data_i};

    // The pace counter only runs while enabled and out of IDLE, so the very
    // first clock in WAIT sees a count of zero and ticks immediately.
    assign tick_s = en_i && (state_r != S_IDLE) && (cnt_r == DIV_ZERO);

    // Reload value for the pace counter; a zero period behaves as one clock.
    always_comb begin
        reload_s = DIV_ZERO;
        if (period_i == DIV_ZERO) begin
            reload_s = DIV_ZERO;
        end else begin
            reload_s = period_i - DIV_ONE;
        end
    end

    // Pace counter: cleared in IDLE, frozen while disabled, reloads on tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= DIV_ZERO;
        end else if (state_r == S_IDLE) begin
            cnt_r <= DIV_ZERO;
        end else if (!en_i) begin
            cnt_r <= cnt_r;
        end else if (cnt_r == DIV_ZERO) begin
            cnt_r <= reload_s;
        end else begin
            cnt_r <= cnt_r - DIV_ONE;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an SPI write in flight always runs through ADV.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (en_i) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!en_i) begin
                    state_nxt_s = S_IDLE;
                end else if (tick_s) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_FETCH: state_nxt_s = S_LOAD;
            S_LOAD:  state_nxt_s = S_STRB;
            S_STRB:  state_nxt_s = S_BUSY;
            S_BUSY: begin
                // Only an end-of-write seen after the strobe counts.
                if (eow_i) begin
                    state_nxt_s = S_ADV;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            S_ADV: begin
                if (en_i) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output/datapath next values; all outputs are registered from these.
    always_comb begin
        addr_nxt_s  = addr_r;
        quad_nxt_s  = quad_r;
        dac_nxt_s   = dac_r;
        ovr_nxt_s   = ovr_r;
        cycle_nxt_s = 1'b0;
        strw_nxt_s  = (state_nxt_s == S_STRB);
        busy_nxt_s  = (state_nxt_s != S_IDLE);

        // Quadrants 0/1 sit above mid-scale, quadrants 2/3 below it.
        if (state_r == S_LOAD) begin
            if (quad_r[1] == 1'b0) begin
                dac_nxt_s = MID_SCALE + lut_ext_s;
            end else begin
                dac_nxt_s = MID_SCALE - lut_ext_s;
            end
        end else begin
            dac_nxt_s = dac_r;
        end

        // Full period done: entering ADV from the last point of quadrant 3.
        if ((state_r == S_BUSY) && (state_nxt_s == S_ADV) &&
            (quad_r == QUAD_LAST) && (addr_r == ADDR_ZERO)) begin
            cycle_nxt_s = 1'b1;
        end else begin
            cycle_nxt_s = 1'b0;
        end

        // Address walk; the end point is held so peaks and zeros repeat.
        if (state_r == S_ADV) begin
            if (quad_r[0] == 1'b0) begin
                if (addr_r == ADDR_LAST) begin
                    quad_nxt_s = quad_r + QUAD_ONE;
                end else begin
                    addr_nxt_s = addr_r + ADDR_ONE;
                end
            end else begin
                if (addr_r == ADDR_ZERO) begin
                    quad_nxt_s = quad_r + QUAD_ONE;
                end else begin
                    addr_nxt_s = addr_r - ADDR_ONE;
                end
            end
        end else begin
            addr_nxt_s = addr_r;
            quad_nxt_s = quad_r;
        end

        // Every return to IDLE restarts the wave from its origin.
        if (state_nxt_s == S_IDLE) begin
            addr_nxt_s = ADDR_ZERO;
            quad_nxt_s = QUAD_ZERO;
        end else begin
            addr_nxt_s = addr_nxt_s;
            quad_nxt_s = quad_nxt_s;
        end

        // A tick outside WAIT is dropped and flagged; a fresh start clears it.
        if ((state_r == S_IDLE) && (state_nxt_s == S_WAIT)) begin
            ovr_nxt_s = 1'b0;
        end else if (tick_s && (state_r != S_WAIT)) begin
            ovr_nxt_s = 1'b1;
        end else begin
            ovr_nxt_s = ovr_r;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r  <= ADDR_ZERO;
            quad_r  <= QUAD_ZERO;
            dac_r   <= MID_SCALE;
            strw_r  <= 1'b0;
            busy_r  <= 1'b0;
            cycle_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            addr_r  <= addr_nxt_s;
            quad_r  <= quad_nxt_s;
            dac_r   <= dac_nxt_s;
            strw_r  <= strw_nxt_s;
            busy_r  <= busy_nxt_s;
            cycle_r <= cycle_nxt_s;
            ovr_r   <= ovr_nxt_s;
        end
    end

    assign lut_addr_o = addr_r;
    assign quad_o     = quad_r;
    assign dac_data_o = dac_r;
    assign strw_o     = strw_r;
    assign busy_o     = busy_r;
    assign cycle_o    = cycle_r;
    assign ovr_o      = ovr_r;

endmodule

// File: tb/tb_dac_sine_sequencer.sv
// Directed bench for dac_sine_sequencer with N_PTS=4 and a LUT returning
// addr*500. The SPI writer is modelled by an end-of-write responder.
module tb_dac_sine_sequencer;

    localparam int N_PTS  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DIV_W-1:0]  period;
    logic [ADDR_W-1:0] lut_addr;
    logic [DATA_W-2:0] lut_data = '0;
    logic [DATA_W-1:0] dac_data;
    logic              strw;
    logic              eow;
    logic              eow_auto;
    logic              eow_man;
    logic [1:0]        quad;
    logic              busy;
    logic              cycle;
    logic              ovr;

    int checks = 0;
    int errors = 0;
    bit resp_en;
    int eow_dly;

    logic [11:0] exp_wave [16] = '{12'd2048, 12'd2548, 12'd3048, 12'd3548,
                                   12'd3548, 12'd3048, 12'd2548, 12'd2048,
                                   12'd2048, 12'd1548, 12'd1048, 12'd548,
                                   12'd548,  12'd1048, 12'd1548, 12'd2048};

    always #5 clk = ~clk;

    assign eow = eow_auto | eow_man;

    // Synchronous quarter-wave ROM model: magnitude = addr * 500.
    always @(posedge clk) lut_data <= 11'(lut_addr * 500);

    dac_sine_sequencer #(
        .N_PTS (N_PTS),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .period_i  (period),
        .lut_addr_o(lut_addr),
        .lut_data_i(lut_data),
        .dac_data_o(dac_data),
        .strw_o    (strw),
        .eow_i     (eow),
        .quad_o    (quad),
        .busy_o    (busy),
        .cycle_o   (cycle),
        .ovr_o     (ovr)
    );

    // SPI writer model: one-clock end-of-write eow_dly clocks after a strobe.
    initial begin
        eow_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && strw) begin
                repeat (eow_dly) @(negedge clk);
                eow_auto = 1'b1;
                @(negedge clk);
                eow_auto = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count falling edges until strw is seen, bounded by budget.
    task automatic wait_strw(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strw && (n < budget));
    endtask

    initial begin
        int n;
        int gap;
        int cyc_cnt;
        int strb_cnt;

        rst = 1'b1; en = 1'b0; period = 16'd40; eow_man = 1'b0;
        resp_en = 1'b1; eow_dly = 10; gap = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strw", strw, 1'b0);
        chk("rst_addr", lut_addr, 0);
        chk("rst_quad", quad, 0);
        chk("rst_dac", dac_data, 2048);
        chk("rst_cycle", cycle, 1'b0);
        chk("rst_ovr", ovr, 1'b0);

        // Full wave at period 40, eow 10 clocks after each strobe.
        en = 1'b1;
        @(negedge clk);
        chk("busy_in_wait", busy, 1'b1);
        wait_strw(10, n);
        chk("first_tick_latency", n, 3);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                wait_strw(60, n);
                chk($sformatf("strw_gap[%0d]", i), gap + n, 40);
            end
            chk($sformatf("wave_dac[%0d]", i), dac_data, exp_wave[i]);
            chk($sformatf("wave_quad[%0d]", i), quad, i / 4);
            @(negedge clk);
            chk($sformatf("strw_width[%0d]", i), strw, 1'b0);
            gap = 1;
        end
        cyc_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (cycle) cyc_cnt++;
        end
        gap = gap + 20;
        chk("cycle_pulses", cyc_cnt, 1);
        chk("wrap_quad", quad, 0);
        chk("wrap_addr", lut_addr, 0);
        chk("no_ovr_at_40", ovr, 1'b0);

        // Second period starts again at mid-scale, then one more point.
        wait_strw(60, n);
        chk("gap_after_cycle", gap + n, 40);
        chk("p2_dac0", dac_data, 2048);
        @(negedge clk);
        gap = 1;
        wait_strw(60, n);
        chk("p2_gap1", gap + n, 40);
        chk("p2_dac1", dac_data, 2548);
        chk("p2_addr1", lut_addr, 1);

        // Enable drop while BUSY: write completes, ADV, then IDLE.
        @(negedge clk);
        en = 1'b0;
        strb_cnt = 0;
        for (int j = 2; j <= 15; j++) begin
            @(negedge clk);
            if (strw) strb_cnt++;
            if (j == 11) chk("drop_busy_in_adv", busy, 1'b1);
            if (j == 12) chk("drop_idle", busy, 1'b0);
        end
        chk("drop_no_restrobe", strb_cnt, 0);
        chk("drop_addr", lut_addr, 0);
        chk("drop_quad", quad, 0);
        chk("drop_dac_hold", dac_data, 2548);

        // Restart; eow coincident with the strobe must be ignored.
        resp_en = 1'b0;
        en = 1'b1;
        wait_strw(10, n);
        chk("restart_latency", n, 4);
        chk("restart_dac", dac_data, 2048);
        chk("restart_quad", quad, 0);
        eow_man = 1'b1;
        @(negedge clk);
        eow_man = 1'b0;
        repeat (5) @(negedge clk);
        chk("eow_strb_busy", busy, 1'b1);
        chk("eow_strb_addr", lut_addr, 0);
        eow_man = 1'b1;
        @(negedge clk);
        eow_man = 1'b0;
        @(negedge clk);
        chk("eow_busy_addr", lut_addr, 1);
        wait_strw(60, n);
        chk("manual_gap", 8 + n, 40);
        chk("manual_dac", dac_data, 2548);

        // Synchronous reset in the middle of BUSY.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_strw", strw, 1'b0);
        chk("midrst_addr", lut_addr, 0);
        chk("midrst_quad", quad, 0);
        chk("midrst_dac", dac_data, 2048);
        rst = 1'b0;
        eow_man = 1'b1;
        @(negedge clk);
        eow_man = 1'b0;
        strb_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (strw) strb_cnt++;
        end
        chk("late_eow_no_strw", strb_cnt, 0);
        chk("late_eow_idle", busy, 1'b0);

        // Overrun: period 8 with a 20-clock SPI write.
        period = 16'd8;
        eow_dly = 20;
        resp_en = 1'b1;
        en = 1'b1;
        wait_strw(10, n);
        chk("ovr_first_latency", n, 4);
        chk("ovr_before", ovr, 1'b0);
        @(negedge clk);
        gap = 1;
        wait_strw(80, n);
        chk("ovr_gap", gap + n, 32);
        chk("ovr_gap_mult8", (gap + n) % 8, 0);
        chk("ovr_set", ovr, 1'b1);
        @(negedge clk);
        en = 1'b0;
        repeat (25) @(negedge clk);
        chk("ovr_idle", busy, 1'b0);
        chk("ovr_sticky", ovr, 1'b1);
        en = 1'b1;
        @(negedge clk);
        chk("ovr_clear_enable", ovr, 1'b0);
        chk("ovr_reenable_busy", busy, 1'b1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_drop_idle", busy, 1'b0);

        // Period 0 behaves as 1: ticks every clock, overrun sets.
        period = 16'd0;
        eow_dly = 3;
        en = 1'b1;
        wait_strw(10, n);
        chk("p0_latency", n, 4);
        chk("p0_ovr", ovr, 1'b1);
        @(negedge clk);
        gap = 1;
        wait_strw(20, n);
        chk("p0_gap", gap + n, 8);
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("p0_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
